// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and address checking for instr_mem_pipe
//
// Contents:
//   NOP_INSTR_DEFAULT : word returned on an errored fetch unless overridden
//   im_entry_t        : default response buffer entry {instr, err, addr}
//   addr_err()        : misaligned / out-of-range test for a byte address
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam int IM_ADDR_WIDTH = 32;
  localparam int IM_DATA_WIDTH = 32;

  typedef struct packed {
    logic [IM_DATA_WIDTH-1:0] instr;
    logic                     err;
    logic [IM_ADDR_WIDTH-1:0] addr;
  } im_entry_t;

  // addr is the byte address zero-extended to 64 bits; bits above aw are
  // masked so the range compare behaves as a full aw-bit compare.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int unsigned aw,
                                    input int unsigned depth);
    logic [63:0] a;
    logic [63:0] lim;
    a   = (aw >= 64) ? addr : (addr & ((64'd1 << aw) - 64'd1));
    lim = 64'(depth) << 2;
    return (a[1:0] != 2'b00) || (a >= lim);
  endfunction

endpackage

// File: rtl/instr_mem_pipe_rsp_fifo2.sv
// rtl/instr_mem_pipe_rsp_fifo2.sv - 2-entry response FIFO with synchronous flush
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : drop all entries; a same-cycle push survives as sole entry
//   push, push_data : qualified write (caller guarantees not full)
//   pop             : qualified read (caller guarantees not empty)
//   head            : oldest entry
//   valid, full     : count != 0, count == 2
//   count           : occupancy 0..2
module rsp_fifo2
  import instr_mem_pkg::*;
#(
  parameter type entry_t = im_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic       valid,
  output logic       full,
  output logic [1:0] count
);

  entry_t     entries_q [2];
  entry_t     entries_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      // Any pop this cycle is meaningless: everything older is discarded.
      rd_ptr_d = 1'b0;
      if (push) begin
        entries_d[0] = push_data;
        wr_ptr_d     = 1'b1;
        count_d      = 2'd1;
      end else begin
        wr_ptr_d = 1'b0;
        count_d  = 2'd0;
      end
    end else begin
      if (push) begin
        entries_d[wr_ptr_q] = push_data;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Entries are reset so the head (and thus the response outputs) reads as
  // zero immediately on reset assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head  = entries_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;

endmodule

// File: rtl/instr_mem_pipe.sv
// rtl/instr_mem_pipe.sv - instruction memory with valid/ready fetch and 2-entry response buffer
//
// Optional feature macro: INSTR_MEM_WRITE_EN (adds a word write port).
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   flush                           : drop buffered responses (synchronous)
//   req_valid, req_ready, req_addr  : fetch request (byte address)
//   rsp_valid, rsp_ready            : response handshake
//   rsp_instr, rsp_err, rsp_addr    : fetched word, error flag, its byte address
//   wr_en, wr_addr, wr_data         : word write port (INSTR_MEM_WRITE_EN only)
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT),
  parameter                        INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic                  rsp_err,
`ifdef INSTR_MEM_WRITE_EN
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`endif
  output logic [ADDR_WIDTH-1:0] rsp_addr
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic                  err;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             accept;
  logic             pop;
  entry_t           push_data;
  entry_t           head;
  logic             fifo_valid;
  logic             fifo_full;
  logic [1:0]       fifo_count;

  assign req_idx = req_addr[IDX_W+1:2];
  assign req_err = addr_err(64'(req_addr), ADDR_WIDTH, DEPTH);

  // req_ready depends only on registered occupancy, never on rsp_ready.
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign pop       = fifo_valid && rsp_ready;

  // The array read is combinational from req_addr and captured into the
  // buffer at the accepting edge, giving one cycle of latency. Because it
  // samples the pre-edge array, a same-edge write is seen as old data.
  always_comb begin
    push_data.instr = req_err ? NOP_INSTR : mem_q[req_idx];
    push_data.err   = req_err;
    push_data.addr  = req_addr;
  end

`ifdef INSTR_MEM_WRITE_EN
  logic             wr_err;
  logic [IDX_W-1:0] wr_idx;

  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_err = addr_err(64'(wr_addr), ADDR_WIDTH, DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en && !wr_err) begin
      mem_q[wr_idx] <= wr_data;
    end
  end
`endif

  rsp_fifo2 #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_instr = head.instr;
  assign rsp_err   = head.err;
  assign rsp_addr  = head.addr;

  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb/tb_instr_mem_pipe.sv - directed self-checking bench for instr_mem_pipe
module tb_instr_mem_pipe;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_instr;
  logic          rsp_err;
  logic [AW-1:0] rsp_addr;
`ifdef INSTR_MEM_WRITE_EN
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instr_mem_pipe #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (1024)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
`ifdef INSTR_MEM_WRITE_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .rsp_addr  (rsp_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef INSTR_MEM_WRITE_EN
    // Load the image through the write port while reset is held.
    wr_en = 1'b1;
    wr_addr = 32'h0;   wr_data = 32'h11; step();
    wr_addr = 32'h4;   wr_data = 32'h22; step();
    wr_addr = 32'h8;   wr_data = 32'h33; step();
    wr_addr = 32'hFFC; wr_data = 32'hABCD_0123; step();
    wr_en = 1'b0;
`else
    for (int i = 0; i < 1024; i++) dut.mem_q[i] = '0;
    dut.mem_q[0]    = 32'h11;
    dut.mem_q[1]    = 32'h22;
    dut.mem_q[2]    = 32'h33;
    dut.mem_q[1023] = 32'hABCD_0123;
`endif
    step();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_instr", rsp_instr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", req_ready, 1);

    // Streaming with consumer always ready.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    chk("t1_valid0", rsp_valid, 1);
    chk("t1_instr0", rsp_instr, 32'h11);
    chk("t1_err0", rsp_err, 0);
    chk("t1_addr0", rsp_addr, 32'h0);
    req_addr = 32'h4;
    step();
    chk("t1_instr1", rsp_instr, 32'h22);
    chk("t1_err1", rsp_err, 0);
    req_addr = 32'h8;
    step();
    chk("t1_instr2", rsp_instr, 32'h33);
    chk("t1_addr2", rsp_addr, 32'h8);
    chk("t1_ready", req_ready, 1);
    req_valid = 1'b0;
    step();
    chk("t1_drained", rsp_valid, 0);

    // Stall: fill the buffer, hold, then drain in order.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    chk("t2_ready_c1", req_ready, 1);
    chk("t2_instr_c1", rsp_instr, 32'h11);
    req_addr = 32'h4;
    step();
    chk("t2_ready_full", req_ready, 0);
    chk("t2_hold_a", rsp_instr, 32'h11);
    req_addr = 32'h8;
    step();
    chk("t2_ready_full2", req_ready, 0);
    chk("t2_hold_b", rsp_instr, 32'h11);
    chk("t2_hold_addr", rsp_addr, 32'h0);
    rsp_ready = 1'b1;
    step();
    chk("t2_drain1", rsp_instr, 32'h22);
    chk("t2_ready_again", req_ready, 1);
    step();
    chk("t2_drain2", rsp_instr, 32'h33);
    chk("t2_drain2_addr", rsp_addr, 32'h8);
    req_valid = 1'b0;
    step();
    chk("t2_empty", rsp_valid, 0);

    // Error cases and the last valid word.
    req_valid = 1'b1; req_addr = 32'h6;
    step();
    chk("t3_mis_err", rsp_err, 1);
    chk("t3_mis_instr", rsp_instr, 32'h0);
    chk("t3_mis_addr", rsp_addr, 32'h6);
    req_addr = 32'h1000;
    step();
    chk("t3_oor_err", rsp_err, 1);
    chk("t3_oor_instr", rsp_instr, 32'h0);
    chk("t3_oor_addr", rsp_addr, 32'h1000);
    req_addr = 32'hFFC;
    step();
    chk("t3_last_err", rsp_err, 0);
    chk("t3_last_instr", rsp_instr, 32'hABCD_0123);
    req_addr = 32'h8000_0004;
    step();
    chk("t3_high_err", rsp_err, 1);
    req_valid = 1'b0;
    step();

    // Flush: full buffer with no request, then flush with a request and a pop.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    chk("t4_full", req_ready, 0);
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_flush_empty", rsp_valid, 0);
    chk("t4_flush_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    chk("t4_one", rsp_instr, 32'h11);
    req_addr = 32'h8; flush = 1'b1; rsp_ready = 1'b1;
    step();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    chk("t4_keep_valid", rsp_valid, 1);
    chk("t4_keep_instr", rsp_instr, 32'h33);
    chk("t4_keep_addr", rsp_addr, 32'h8);
    chk("t4_keep_ready", req_ready, 1);
    rsp_ready = 1'b1;
    step();
    chk("t4_sole_entry", rsp_valid, 0);

    // Asynchronous reset with the buffer full.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_addr = 32'h8;
    step();
    chk("t5_full", req_ready, 0);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", rsp_valid, 0);
    chk("t5_async_instr", rsp_instr, 0);
    chk("t5_async_addr", rsp_addr, 0);
    chk("t5_async_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_rel_valid", rsp_valid, 0);
    chk("t5_rel_ready", req_ready, 1);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h8;
    step();
    chk("t5_resume", rsp_instr, 32'h33);
    req_valid = 1'b0;
    step();

`ifdef INSTR_MEM_WRITE_EN
    // Read-first on a same-cycle read/write to one word.
    req_valid = 1'b1; req_addr = 32'h4;
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    chk("t6_read_first", rsp_instr, 32'h22);
    step();
    chk("t6_new_data", rsp_instr, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h2; wr_data = 32'h5555_5555;
    step();
    wr_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    chk("t6_mis_write_ignored", rsp_instr, 32'h11);
    req_valid = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
